// File: rtl/dmem_pkg.sv
// Shared types, limits and the address legality helper for the data-memory responder.
package dmem_pkg;

  // Deepest read-return pipeline the responder supports.
  localparam int unsigned MAX_READ_LATENCY = 4;

  // One slot of the read-return pipeline.
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_stage_t;

  // A byte address is legal when it is word aligned and falls inside the
  // window [base, base + 4 * 2**addr_bits). The math is done at 34 bits so a
  // window reaching the top of the 32-bit space does not wrap.
  function automatic logic is_legal(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned addr_bits);
    logic [33:0] off;
    logic [33:0] span;
    off  = {2'b00, addr} - {2'b00, base};
    span = 34'd4 << addr_bits;
    return (addr[1:0] == 2'b00) && (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Fixed-depth read-return shift register. Advances every cycle with no stall;
// reset empties every slot so nothing in flight survives it.
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  rd_stage_t stage_i,
  output rd_stage_t stage_o
);

  rd_stage_t stage_q [DEPTH];

  // Shift the read slots one position per cycle; reset clears them all.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '{valid: 1'b0, data: 32'h0000_0000};
      end
    end else begin
      stage_q[0] <= stage_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign stage_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array, legality check, read-return pipeline,
// shared-bus tri-state drive, sticky error flag and bus-conflict counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr,
  inout  wire  [31:0] dmem_data,
  input  logic        dmem_wen,
  output logic        rd_valid,
  output logic        err,
  output logic [15:0] conflict_cnt
);

  localparam int unsigned WORDS = 32'd1 << ADDR_BITS;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("dmem_responder: READ_LATENCY must be within 1..4");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("dmem_responder: BASE_ADDR must be 4-byte aligned");
    end
  endgenerate

  logic                 legal_s;
  logic [ADDR_BITS-1:0] idx_s;
  rd_stage_t            stage_in_s;
  rd_stage_t            stage_last_s;
  logic                 rd_valid_s;
  logic                 err_q;
  logic                 err_d;
  logic [15:0]          cnt_q;
  logic [15:0]          cnt_d;
  logic [31:0]          mem_q [WORDS];

  // Decode the core's byte address into legality and a word index.
  always_comb begin
    legal_s = is_legal(dmem_addr, BASE_ADDR, ADDR_BITS);
    idx_s   = ADDR_BITS'((dmem_addr - BASE_ADDR) >> 32'd2);
  end

  // Every non-write cycle is a read; illegal reads return zero.
  always_comb begin
    stage_in_s.valid = ~dmem_wen;
    if (legal_s) begin
      stage_in_s.data = mem_q[idx_s];
    end else begin
      stage_in_s.data = 32'h0000_0000;
    end
  end

  dmem_rd_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i   (clk),
    .rst_i   (reset),
    .stage_i (stage_in_s),
    .stage_o (stage_last_s)
  );

  // Drive the bus only with a pending return and only when the core is not writing.
  always_comb begin
    rd_valid_s = stage_last_s.valid & ~dmem_wen;
  end

  assign dmem_data = rd_valid_s ? stage_last_s.data : 32'hzzzz_zzzz;
  assign rd_valid  = rd_valid_s;

  // Next state for the sticky error flag and the saturating conflict counter.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (!legal_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    if (stage_last_s.valid && dmem_wen && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Status registers; cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= 16'h0000;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err          = err_q;
  assign conflict_cnt = cnt_q;

  // Commit legal writes; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (dmem_wen && legal_s) begin
      mem_q[idx_s] <= dmem_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (latency 1, 2, 4) share one stimulus
// stream; a reference model queues expected returns and a negedge monitor
// compares each responder's bus behaviour against them.
module tb_dmem_responder;

  typedef struct {
    int          due;
    bit          known;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wen = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  wire  [31:0] bus0;
  wire  [31:0] bus1;
  wire  [31:0] bus2;
  logic        rv [3];
  logic        er [3];
  logic [15:0] cc [3];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          first_err = -1;
  int          m_cnt [3];
  logic [31:0] mem_m [int];
  exp_t        exp_q [3][$];
  bit          run = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus0 = wen ? wdata : 32'hzzzz_zzzz;
  assign bus1 = wen ? wdata : 32'hzzzz_zzzz;
  assign bus2 = wen ? wdata : 32'hzzzz_zzzz;

  dmem_responder #(.ADDR_BITS(10), .READ_LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
    .clk(clk), .reset(reset), .dmem_addr(addr), .dmem_data(bus0), .dmem_wen(wen),
    .rd_valid(rv[0]), .err(er[0]), .conflict_cnt(cc[0]));
  dmem_responder #(.ADDR_BITS(10), .READ_LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
    .clk(clk), .reset(reset), .dmem_addr(addr), .dmem_data(bus1), .dmem_wen(wen),
    .rd_valid(rv[1]), .err(er[1]), .conflict_cnt(cc[1]));
  dmem_responder #(.ADDR_BITS(10), .READ_LATENCY(4), .BASE_ADDR(32'h0)) u_l4 (
    .clk(clk), .reset(reset), .dmem_addr(addr), .dmem_data(bus2), .dmem_wen(wen),
    .rd_valid(rv[2]), .err(er[2]), .conflict_cnt(cc[2]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s L=%0d cyc=%0d: actual %h required %h", nm, lat_of(k), cyc, act, exp);
    end
  endtask

  // One bus cycle of stimulus plus the reference model's view of it.
  task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d);
    bit   legal;
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wen   = w;
    addr  = a;
    wdata = d;
    legal = (a % 4 == 0) && (a < 32'h1000);
    if (!legal && first_err < 0) first_err = cyc;
    if (w) begin
      if (legal) mem_m[int'(a / 4)] = d;
    end else begin
      for (int k = 0; k < 3; k++) begin
        e.due   = cyc + lat_of(k);
        e.known = legal ? mem_m.exists(int'(a / 4)) : 1'b1;
        e.data  = (legal && e.known) ? mem_m[int'(a / 4)] : 32'h0;
        exp_q[k].push_back(e);
      end
    end
  endtask

  // Assert reset mid-cycle, confirm the bus is released at once, and hold.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      m_cnt[k] = 0;
    end
    first_err = -1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_reset_rd_valid", k, {31'h0, rv[k]}, 32'h0);
      chk("async_reset_err", k, {31'h0, er[k]}, 32'h0);
      chk("async_reset_cnt", k, {16'h0, cc[k]}, 32'h0);
    end
    repeat (hold) @(posedge clk);
  endtask

  task automatic mon(input int k);
    logic [31:0] b;
    exp_t        e;
    case (k)
      0:       b = bus0;
      1:       b = bus1;
      default: b = bus2;
    endcase
    if (reset) begin
      chk("reset_rd_valid", k, {31'h0, rv[k]}, 32'h0);
      chk("reset_err", k, {31'h0, er[k]}, 32'h0);
      chk("reset_cnt", k, {16'h0, cc[k]}, 32'h0);
    end else begin
      chk("err", k, {31'h0, er[k]}, {31'h0, (first_err >= 0 && cyc > first_err)});
      chk("conflict_cnt", k, {16'h0, cc[k]}, m_cnt[k]);
      while (exp_q[k].size() > 0 && exp_q[k][0].due < cyc) begin
        e = exp_q[k].pop_front();
        checks++;
        errors++;
        $display("FAIL missed_return L=%0d cyc=%0d: actual none required return due %0d", lat_of(k), cyc, e.due);
      end
      if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
        e = exp_q[k].pop_front();
        if (wen) begin
          chk("conflict_no_drive", k, {31'h0, rv[k]}, 32'h0);
          chk("conflict_bus", k, b, wdata);
          if (m_cnt[k] < 65535) m_cnt[k]++;
        end else begin
          chk("rd_valid", k, {31'h0, rv[k]}, 32'h1);
          if (e.known) chk("rd_data", k, b, e.data);
        end
      end else begin
        chk("idle_no_drive", k, {31'h0, rv[k]}, 32'h0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 3; k++) mon(k);
    end
  end

  initial begin
    logic [31:0] a;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    run = 1'b1;
    repeat (3) @(posedge clk);

    // Release reset into a stream of reads: nothing returns before the latency.
    for (int i = 0; i < 6; i++) step(1'b0, 32'h40, 32'h0);

    // Fill a few words so later reads have known contents.
    for (int i = 0; i < 16; i++) step(1'b1, i * 4, $urandom);
    step(1'b1, 32'hFFC, $urandom);

    // Write then read back the same word.
    step(1'b1, 32'h40, 32'hCAFE_F00D);
    step(1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0);

    // Read returns the value at issue even if a write follows immediately.
    step(1'b1, 32'h8, 32'hAAAA_0001);
    step(1'b0, 32'h8, 32'h0);
    step(1'b1, 32'h8, 32'hBBBB_0002);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h8, 32'h0);

    // Write lands on a return cycle: return dropped and counted.
    step(1'b0, 32'h10, 32'h0);
    step(1'b0, 32'h10, 32'h0);
    step(1'b1, 32'h20, 32'h2020_2020);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h20, 32'h0);

    // Misaligned and out-of-range reads return zero and latch the error.
    step(1'b0, 32'h42, 32'h0);
    step(1'b0, 32'h1000, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h4, 32'h0);
    step(1'b1, 32'h4, 32'h4444_4444);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h4, 32'h0);

    // Reset with reads in flight.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0);
    do_reset(2);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h40, 32'h0);

    // Randomised traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5)       a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
      else if (r < 8)  a = 32'h1000 + ($urandom_range(0, 255) * 4);
      else if (r < 12) a = 32'hFFC;
      else             a = $urandom_range(0, 15) * 4;
      if (i == 200) do_reset(1);
      step($urandom_range(0, 99) < 30, a, $urandom);
    end

    @(negedge clk);
    #1;
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
